// File: rtl/digit_scan_mux.sv
// Time-multiplexes NUM_DIGITS snapshot bytes onto one segment bus with blanking gaps.
// Optional hex-to-7-segment decode when DIGIT_DECODE_EN is defined.
module digit_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_DIGITS*8-1:0] digits_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done,
  input  logic                    scan_in0,
  input  logic                    scan_en,
  output logic                    scan_out0
);

  localparam int unsigned MaxCyc = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                index_q, index_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][7:0]     snap_q, snap_d;
  logic [7:0]                     seg_d;
  logic [NUM_DIGITS-1:0]          sel_d;
  logic                           done_d;

  // DFT ports are stitched later; they carry no function here.
  logic unused_scan;
  assign unused_scan = scan_in0 ^ scan_en;
  assign scan_out0   = 1'b0;

`ifdef DIGIT_DECODE_EN
  function automatic logic [6:0] hex_seg(input logic [3:0] hex);
    logic [6:0] s;
    s = '0;
    unique case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    if (!enable) begin
      state_d = StIdle;
      index_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          index_d = '0;
          cnt_d   = '0;
          snap_d  = digits_in;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (cnt_q == DwellLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            // Wrapping to digit 0 starts a new frame: take a fresh coherent snapshot.
            if (index_q == IdxLast) begin
              index_d = '0;
              snap_d  = digits_in;
            end else begin
              index_d = index_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          index_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from next-state values so the registers match the state they accompany.
  always_comb begin
    seg_d  = '0;
    sel_d  = '0;
    done_d = 1'b0;
    if (state_d == StDrive) begin
      sel_d  = NUM_DIGITS'(1) << index_d;
`ifdef DIGIT_DECODE_EN
      seg_d  = {snap_d[index_d][7], hex_seg(snap_d[index_d][3:0])};
`else
      seg_d  = snap_d[index_d];
`endif
      done_d = (index_d == IdxLast) && (cnt_d == DwellLast);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      index_q    <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      seg_out    <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      seg_out    <= seg_d;
      dig_sel    <= sel_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux: directed table, hand sequences and a random run
// checked against a frame-position reference model.
module tb_digit_scan_mux;

  localparam int N     = 4;
  localparam int D     = 8;
  localparam int B     = 2;
  localparam int SLOT  = B + D;
  localparam int FRAME = N * SLOT;

  localparam logic [7:0] HexSeg [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] digits_in;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;
  logic        scan_in0;
  logic        scan_en;
  logic        scan_out0;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame position since the frame started, plus the frame's snapshot.
  bit          m_active;
  int          m_pos;
  logic [31:0] m_snap;
  logic [3:0]  prev_sel;
  int          k;

  typedef struct {
    int         cyc;
    logic [7:0] raw;
    logic [3:0] sel;
    logic       done;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  digit_scan_mux #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digits_in (digits_in),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_done(frame_done),
    .scan_in0  (scan_in0),
    .scan_en   (scan_en),
    .scan_out0 (scan_out0)
  );

  function automatic logic [7:0] seg_of(input logic [7:0] raw);
`ifdef DIGIT_DECODE_EN
    logic [7:0] s;
    s = HexSeg[raw[3:0]];
    return {raw[7], s[6:0]};
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [12:0] model_out();
    int          slot;
    int          off;
    logic [31:0] sh;
    logic [12:0] r;
    r = '0;
    if (m_active) begin
      slot = m_pos / SLOT;
      off  = m_pos % SLOT;
      if (off >= B) begin
        sh = m_snap >> (8 * slot);
        r  = {seg_of(sh[7:0]), 4'(1 << slot), (slot == N - 1) && (off == SLOT - 1)};
      end
    end
    return r;
  endfunction

  task automatic step();
    logic        en_s;
    logic [31:0] d_s;
    logic        bad;
    en_s = enable;
    d_s  = digits_in;
    @(posedge clk);
    #1;
    k++;
    if (!en_s) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_snap   = d_s;
    end else begin
      m_pos++;
      if (m_pos == FRAME) begin
        m_pos  = 0;
        m_snap = d_s;
      end
    end
    chk("outputs", {19'd0, seg_out, dig_sel, frame_done}, {19'd0, model_out()});
    chk("scan_out0", {31'd0, scan_out0}, 32'd0);
    bad = ($countones(dig_sel) > 1) ||
          ((prev_sel != 4'd0) && (dig_sel != 4'd0) && (prev_sel != dig_sel));
    chk("sel_onehot_gap", {31'd0, bad}, 32'd0);
    prev_sel = dig_sel;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset", {19'd0, seg_out, dig_sel, frame_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    m_active = 1'b0;
    prev_sel = '0;
    k        = 0;
  endtask

  task automatic run_to_pos(input int pos);
    int n;
    n = 0;
    while (!(m_active && m_pos == pos) && n < 200) begin
      step();
      n++;
    end
    chk("reach_pos", {31'd0, (m_active && m_pos == pos)}, 32'd1);
  endtask

  initial begin
    vecs = '{
      '{1,  8'h00, 4'b0000, 1'b0}, '{2,  8'h00, 4'b0000, 1'b0},
      '{3,  8'h11, 4'b0001, 1'b0}, '{10, 8'h11, 4'b0001, 1'b0},
      '{11, 8'h00, 4'b0000, 1'b0}, '{12, 8'h00, 4'b0000, 1'b0},
      '{13, 8'h22, 4'b0010, 1'b0}, '{23, 8'h33, 4'b0100, 1'b0},
      '{33, 8'h44, 4'b1000, 1'b0}, '{39, 8'h44, 4'b1000, 1'b0},
      '{40, 8'h44, 4'b1000, 1'b1}, '{41, 8'h00, 4'b0000, 1'b0},
      '{43, 8'hAA, 4'b0001, 1'b0}, '{53, 8'hBB, 4'b0010, 1'b0}
    };
    m_active  = 1'b0;
    m_pos     = 0;
    m_snap    = '0;
    prev_sel  = '0;
    k         = 0;
    scan_in0  = 1'b0;
    scan_en   = 1'b0;
    enable    = 1'b1;
    digits_in = 32'h4433_2211;
    reset     = 1'b1;
    #1;
    chk("reset_state", {18'd0, seg_out, dig_sel, frame_done, scan_out0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven first frames; digits change mid-frame during digit 1.
    for (int c = 0; c < 55; c++) begin
      step();
      foreach (vecs[i]) begin
        if (vecs[i].cyc == k)
          chk($sformatf("vec%0d", i), {19'd0, seg_out, dig_sel, frame_done},
              {19'd0, seg_of(vecs[i].raw), vecs[i].sel, vecs[i].done});
      end
      if (k == 15) digits_in = 32'hDDCC_BBAA;
    end

    // Drop enable during digit 2 drive, then restart with a fresh snapshot.
    run_to_pos(25);
    enable = 1'b0;
    step();
    chk("disable_dark", {19'd0, seg_out, dig_sel, frame_done}, 32'd0);
    digits_in = 32'h5566_7788;
    enable    = 1'b1;
    step();
    chk("reenable_blank0", {28'd0, dig_sel}, 32'd0);
    step();
    chk("reenable_blank1", {28'd0, dig_sel}, 32'd0);
    step();
    chk("reenable_digit0", {20'd0, seg_out, dig_sel}, {20'd0, seg_of(8'h88), 4'b0001});

    // Asynchronous reset in the middle of digit 2 drive.
    run_to_pos(24);
    chk("pre_reset_sel", {28'd0, dig_sel}, 32'd4);
    do_reset();
    for (int c = 0; c < 3; c++) step();
    chk("post_reset_digit0", {20'd0, seg_out, dig_sel}, {20'd0, seg_of(8'h88), 4'b0001});

    // Decode-oriented pattern for one full frame.
    digits_in = 32'h8F0A_0380;
    run_to_pos(0);
    for (int c = 0; c < FRAME; c++) step();

    // Randomized run against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0) digits_in = $urandom;
      enable = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
